// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer.
// Opcodes, sequencer states and ALU operation encodings.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_LW   = 4'h4;
    localparam logic [3:0] OP_SW   = 4'h5;
    localparam logic [3:0] OP_BNE  = 4'h6;
    localparam logic [3:0] OP_J    = 4'h7;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_FETCH  = 3'd1;
    localparam state_t S_DECODE = 3'd2;
    localparam state_t S_EXEC   = 3'd3;
    localparam state_t S_MEM    = 3'd4;
    localparam state_t S_WB     = 3'd5;
    localparam state_t S_HALT   = 3'd6;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= OP_J) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unacknowledged MEM cycles and flags the last allowed one.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [3:0] LIMIT = 4'(TIMEOUT - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 4'd1;
        end
    end

    // high during the TIMEOUT-th waiting cycle, so its closing edge errors
    assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control,
// retired-instruction count and halt on illegal opcode or memory timeout.
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [3:0]  opcode,
    input  logic        alu_zero,
    input  logic        mem_ack,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        wb_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        halted,
    output logic        error,
    output logic [15:0] retired
);

    state_t     state;
    state_t     state_n;
    logic [3:0] op_q;
    logic       retire;
    logic       set_err;
    logic       in_mem;
    logic       expired;

    assign in_mem = (state == S_MEM);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_mem),
        .en      (in_mem && !mem_ack),
        .expired (expired)
    );

    always_comb begin
        state_n = state;
        retire  = 1'b0;
        set_err = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_n = S_FETCH;
            end
            S_FETCH: begin
                state_n = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    !op_legal(opcode): begin
                        state_n = S_HALT;
                        set_err = 1'b1;
                    end
                    opcode == OP_J,
                    opcode == OP_NOP: begin
                        state_n = S_FETCH;
                        retire  = 1'b1;
                    end
                    opcode == OP_HLT: begin
                        state_n = S_HALT;
                        retire  = 1'b1;
                    end
                    default: state_n = S_EXEC;
                endcase
            end
            S_EXEC: begin
                unique case (1'b1)
                    op_q == OP_BNE: begin
                        state_n = S_FETCH;
                        retire  = 1'b1;
                    end
                    op_q == OP_LW,
                    op_q == OP_SW: state_n = S_MEM;
                    default:       state_n = S_WB;
                endcase
            end
            S_MEM: begin
                // an ack on the final waiting edge beats the timeout
                if (mem_ack) begin
                    if (op_q == OP_SW) begin
                        state_n = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (expired) begin
                    state_n = S_HALT;
                    set_err = 1'b1;
                end
            end
            S_WB: begin
                state_n = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT: begin
                state_n = S_HALT;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= '0;
            retired <= '0;
            error   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_DECODE) op_q <= opcode;
            if (retire) retired <= retired + 16'd1;
            if (set_err) error <= 1'b1;
        end
    end

    always_comb begin
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        alu_src   = 1'b0;
        alu_op    = ALU_ADD;
        reg_write = 1'b0;
        wb_sel    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            S_FETCH: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
            end
            S_DECODE: begin
                pc_load = (opcode == OP_J);
            end
            S_EXEC: begin
                unique case (1'b1)
                    op_q == OP_ADDI,
                    op_q == OP_LW,
                    op_q == OP_SW: begin
                        alu_src = 1'b1;
                        alu_op  = ALU_ADD;
                    end
                    op_q == OP_SUB: alu_op = ALU_SUB;
                    op_q == OP_AND: alu_op = ALU_AND;
                    op_q == OP_BNE: begin
                        alu_op  = ALU_SUB;
                        pc_load = !alu_zero;
                    end
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_SW);
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (op_q == OP_LW);
            end
            default: ;
        endcase
    end

    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: per-cycle expected outputs are
// queued as stimulus is driven and checked at the following negedge.
module tb_cpu_seq_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        alu_zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        ir_load, pc_inc, pc_load, alu_src;
    logic [1:0]  alu_op;
    logic        reg_write, wb_sel, mem_req, mem_we;
    logic        halted, error;
    logic [15:0] retired;

    cpu_seq_ctrl #(
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .opcode    (opcode),
        .alu_zero  (alu_zero),
        .mem_ack   (mem_ack),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .halted    (halted),
        .error     (error),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // {ir_load,pc_inc,pc_load,alu_src,alu_op,reg_write,wb_sel,mem_req,mem_we,halted,error}
    logic [11:0] obs;
    assign obs = {ir_load, pc_inc, pc_load, alu_src, alu_op,
                  reg_write, wb_sel, mem_req, mem_we, halted, error};

    localparam logic [11:0] E_NONE     = 12'h000;
    localparam logic [11:0] E_FETCH    = 12'hC00;
    localparam logic [11:0] E_DEC_J    = 12'h200;
    localparam logic [11:0] E_ADDI     = 12'h100;
    localparam logic [11:0] E_SUB      = 12'h040;
    localparam logic [11:0] E_AND      = 12'h080;
    localparam logic [11:0] E_LSX      = 12'h100;
    localparam logic [11:0] E_BNE_TK   = 12'h240;
    localparam logic [11:0] E_BNE_NT   = 12'h040;
    localparam logic [11:0] E_MEM_LW   = 12'h008;
    localparam logic [11:0] E_MEM_SW   = 12'h00C;
    localparam logic [11:0] E_WB_ALU   = 12'h020;
    localparam logic [11:0] E_WB_LW    = 12'h030;
    localparam logic [11:0] E_HALT     = 12'h002;
    localparam logic [11:0] E_HALT_ERR = 12'h003;

    typedef struct packed {
        logic [11:0] v;
        logic [15:0] r;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] ret = 16'h0;

    task automatic drive(input logic r, input logic rn, input logic [3:0] op,
                         input logic az, input logic ack,
                         input logic [11:0] ev);
        @(posedge clk);
        #1;
        rst = r;
        run = rn;
        opcode = op;
        alu_zero = az;
        mem_ack = ack;
        sbq.push_back('{v: ev, r: ret});
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic rq[4];
        logic nq[4];
        rq = '{1'b1, 1'b1, 1'b0, 1'b0};
        nq = '{1'b0, 1'b0, 1'b0, 1'b1};
        ret = 16'h0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(rq[i], nq[i], 4'h0, 1'b0, 1'b0, E_NONE);
            e = sbq.pop_front();
            checks++;
            if (obs !== e.v || retired !== e.r) begin
                failures++;
                $display("FAIL reset[%0d] got outs=%h ret=%h want outs=%h ret=%h",
                         i, obs, retired, e.v, e.r);
            end
        end
    endtask

    task automatic test_alu(input string nm, input logic [3:0] op,
                            input logic [11:0] ex);
        logic [11:0] ev[4];
        ev = '{E_FETCH, E_NONE, ex, E_WB_ALU};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i == 0), op, 1'b0, 1'b0, ev[i]);
            e = sbq.pop_front();
            checks++;
            if (obs !== e.v || retired !== e.r) begin
                failures++;
                $display("FAIL %s[%0d] got outs=%h ret=%h want outs=%h ret=%h",
                         nm, i, obs, retired, e.v, e.r);
            end
        end
        ret++;
    endtask

    task automatic test_bne(input logic az);
        logic [11:0] ev[3];
        ev = '{E_FETCH, E_NONE, (az ? E_BNE_NT : E_BNE_TK)};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, OP_BNE, az, 1'b0, ev[i]);
            e = sbq.pop_front();
            checks++;
            if (obs !== e.v || retired !== e.r) begin
                failures++;
                $display("FAIL bne_az%0d[%0d] got outs=%h ret=%h want outs=%h ret=%h",
                         az, i, obs, retired, e.v, e.r);
            end
        end
        ret++;
    endtask

    task automatic test_jump_nop(input string nm, input logic [3:0] op,
                                 input logic [11:0] dv);
        logic [11:0] ev[2];
        ev = '{E_FETCH, dv};
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, op, 1'b0, 1'b0, ev[i]);
            e = sbq.pop_front();
            checks++;
            if (obs !== e.v || retired !== e.r) begin
                failures++;
                $display("FAIL %s[%0d] got outs=%h ret=%h want outs=%h ret=%h",
                         nm, i, obs, retired, e.v, e.r);
            end
        end
        ret++;
    endtask

    task automatic test_mem(input string nm, input logic [3:0] op,
                            input int waits, input bit acked);
        logic [11:0] evq[$];
        logic        aq[$];
        logic        nq[$];
        logic [11:0] mv;
        mv = (op == OP_LW) ? E_MEM_LW : E_MEM_SW;
        evq = '{E_FETCH, E_NONE, E_LSX};
        aq  = '{1'b0, 1'b0, 1'b0};
        nq  = '{1'b0, 1'b1, 1'b0};
        repeat (waits) begin
            evq.push_back(mv); aq.push_back(1'b0); nq.push_back(1'b0);
        end
        if (acked) begin
            evq.push_back(mv); aq.push_back(1'b1); nq.push_back(1'b0);
            if (op == OP_LW) begin
                evq.push_back(E_WB_LW); aq.push_back(1'b0); nq.push_back(1'b0);
            end
        end else begin
            repeat (3) begin
                evq.push_back(E_HALT_ERR); aq.push_back(1'b0); nq.push_back(1'b1);
            end
        end
        for (int i = 0; i < evq.size(); i++) begin
            drive(1'b0, nq[i], op, 1'b0, aq[i], evq[i]);
            e = sbq.pop_front();
            checks++;
            if (obs !== e.v || retired !== e.r) begin
                failures++;
                $display("FAIL %s[%0d] got outs=%h ret=%h want outs=%h ret=%h",
                         nm, i, obs, retired, e.v, e.r);
            end
        end
        if (acked) ret++;
    endtask

    task automatic test_halt(input string nm, input logic [3:0] op,
                             input logic err);
        logic [11:0] ev[4];
        ev = '{E_FETCH, E_NONE, (err ? E_HALT_ERR : E_HALT),
               (err ? E_HALT_ERR : E_HALT)};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i >= 2), op, 1'b0, 1'b0, ev[i]);
            e = sbq.pop_front();
            checks++;
            if (obs !== e.v || retired !== e.r) begin
                failures++;
                $display("FAIL %s[%0d] got outs=%h ret=%h want outs=%h ret=%h",
                         nm, i, obs, retired, e.v, e.r);
            end
            if (i == 1 && !err) ret++;
        end
    endtask

    task automatic test_rst_mid_mem();
        logic [11:0] ev[8];
        logic        rq[8];
        logic        nq[8];
        ev = '{E_FETCH, E_NONE, E_LSX, E_MEM_LW, E_MEM_LW,
               E_NONE, E_NONE, E_FETCH};
        rq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        nq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(rq[i], nq[i], OP_LW, 1'b0, 1'b0, ev[i]);
            e = sbq.pop_front();
            checks++;
            if (obs !== e.v || retired !== e.r) begin
                failures++;
                $display("FAIL rst_mid_mem[%0d] got outs=%h ret=%h want outs=%h ret=%h",
                         i, obs, retired, e.v, e.r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu("addi", OP_ADDI, E_ADDI);
        test_alu("sub", OP_SUB, E_SUB);
        test_alu("and", OP_AND, E_AND);
        test_bne(1'b0);
        test_bne(1'b1);
        test_jump_nop("jump", OP_J, E_DEC_J);
        test_jump_nop("nop", OP_NOP, E_NONE);
        test_mem("lw_wait3", OP_LW, 3, 1'b1);
        test_mem("sw_nowait", OP_SW, 0, 1'b1);
        test_mem("lw_nowait", OP_LW, 0, 1'b1);
        test_mem("sw_ack_last", OP_SW, 14, 1'b1);
        test_mem("sw_timeout", OP_SW, 15, 1'b0);
        test_reset();
        test_halt("illegal", 4'b1010, 1'b1);
        test_reset();
        test_halt("hlt", OP_HLT, 1'b0);
        test_reset();
        test_rst_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
